div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle sequencer for the M-extension divide/remainder operations (DIV, DIVU, REM, REMU) of the 3-stage RISC-V core. The control unit decodes the instruction. This block then runs a radix-2 restoring division over WIDTH cycles and holds the pipeline with a stall signal while it runs. It sits beside the ALU in the EX stage, and its result is muxed onto the writeback path when done pulses.

## Interface
- WIDTH, 32: operand and result width in bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX stage holds a divide op; sampled only in IDLE.
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; captured with start.
- dividend  in  WIDTH  rs1 value; captured with start.
- divisor  in  WIDTH  rs2 value; captured with start.
- flush  in  1  pipeline kill; aborts the current operation.
- stall_EX  out  1  freezes the IF/EX registers while a division is pending.
- busy  out  1  state is neither IDLE nor DONE.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  WIDTH  quotient or remainder, per the captured op.

## Operation
- Reset value of every output is 0: stall_EX=0, busy=0, done=0, result=0. State resets to IDLE and the counter to 0.
- States are IDLE, RUN, FIX and DONE.
- IDLE to RUN: start=1 and flush=0 at the edge. The block latches op, the sign flags, and the absolute values of the operands (DIVU/REMU use the raw values). It loads quotient=|dividend|, remainder=0 and count=WIDTH-1.
- IDLE to DONE (fast path) applies on the same edge for these special cases:
  - divisor==0: quotient is all ones; remainder is the dividend.
  - Signed overflow (dividend=0x80..0 and divisor=all ones, DIV/REM only): quotient is 0x80..0; remainder is 0.
- RUN performs one restoring step per cycle:
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor using WIDTH+1 bit arithmetic.
  - If the trial is non-negative, keep the difference and set quo[0]=1.
  - After the step with count==0, go to FIX; otherwise decrement count.
- FIX applies sign correction:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative (signed ops only).
  - Select the quotient or remainder into result, then go to DONE.
- DONE: done=1 for exactly one cycle, then the block returns to IDLE. result holds until the next capture.
- A start seen while busy is ignored and is never queued.
- flush in RUN or FIX goes to IDLE with no done pulse and result unchanged. flush in IDLE blocks a start on the same edge.
- Reset mid-operation aborts immediately to IDLE, with all outputs at their reset values.

## Timing
- stall_EX = (state==IDLE && start && !flush) || state==RUN || state==FIX. The IDLE term is combinational on start, so the pipeline freezes in the same cycle the divide is presented.
- stall_EX is 0 in DONE, so EX writes back result on that edge.
- Normal latency: start is sampled at edge N. RUN covers edges N+1..N+WIDTH, FIX is edge N+WIDTH+1, and done is high in the cycle after edge N+WIDTH+1. That is WIDTH+2 cycles, which is 34 for WIDTH=32.
- Fast-path latency: done is high in the cycle after edge N.
- Back-to-back divides: a new start is accepted on the edge that leaves DONE. No idle bubble is required beyond DONE.

## Structure
- A shared package (cpu_pkg) holds:
  - div_op_t enum: DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11.
  - div_state_t enum: IDLE, RUN, FIX, DONE.
  - The ALU opcode constants 4'b1110 and 4'b1111, which the control unit maps onto div_op_t.
- Single module with no sub-module. The per-cycle restoring step is inline combinational logic feeding the registers.

## Test plan
- DIV 100/7: start at edge 0 -> stall_EX high for 33 cycles, done at cycle 34, result=14. Repeat with REM -> result=2.
- DIV -7/2 -> result=0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF. REMU 0xFFFFFFFF/16 -> 15.
- Divide by zero:
  - DIV 5/0 -> done one cycle after start, result=0xFFFFFFFF.
  - REM 5/0 -> result=5.
  - stall_EX high only in the start cycle.
- Overflow:
  - DIV 0x80000000/0xFFFFFFFF -> fast path, result=0x80000000.
  - REM of the same operands -> result=0.
- Abort and ignored start:
  - flush at RUN cycle 10 -> no done, busy=0 next cycle, result keeps its prior value.
  - A start asserted at RUN cycle 5 with different operands does not alter the final result.
- Reset and back-to-back:
  - rst_n low mid-RUN -> all outputs 0 asynchronously. A fresh DIVU 9/3 afterwards -> 3.
  - A second start issued in the DONE cycle is accepted.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared encodings for the EX-stage divide sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;

    // ALU opcodes the control unit maps onto div_op_t
    localparam logic [3:0] ALU_OP_DIV = 4'b1110;
    localparam logic [3:0] ALU_OP_REM = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// div_sequencer : radix-2 restoring DIV/DIVU/REM/REMU with pipeline stall
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             stall_EX,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             neg_r;
    logic             sel_rem;

    div_op_t          op_e;
    logic             is_signed;
    logic             is_rem;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic             div_zero;
    logic             ovf;
    logic             accept;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] rem_nxt;

    always_comb begin
        op_e      = div_op_t'(op);
        is_signed = (op_e == DIV) || (op_e == REM);
        is_rem    = (op_e == REM) || (op_e == REMU);
        dvd_neg   = is_signed & dividend[WIDTH-1];
        dvs_neg   = is_signed & divisor[WIDTH-1];
        abs_dvd   = dvd_neg ? (~dividend + 1'b1) : dividend;
        abs_dvs   = dvs_neg ? (~divisor + 1'b1) : divisor;
        div_zero  = (divisor == '0);
        ovf       = is_signed && (dividend == MIN_INT) && (divisor == '1);
        accept    = start && !flush;
    end

    // One restoring step; bit WIDTH of the trial is the borrow, since rem < dvsr
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvsr};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                // DONE accepts a new start so back-to-back divides need no bubble
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept) begin
                        sel_rem <= is_rem;
                        neg_q   <= dvd_neg ^ dvs_neg;
                        neg_r   <= dvd_neg;
                        quo     <= abs_dvd;
                        rem     <= '0;
                        dvsr    <= abs_dvs;
                        count   <= CW'(WIDTH - 1);
                        if (div_zero) begin
                            result <= is_rem ? dividend : '1;
                            state  <= DONE;
                        end else if (ovf) begin
                            result <= is_rem ? '0 : MIN_INT;
                            state  <= DONE;
                        end else begin
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        quo <= quo_nxt;
                        rem <= rem_nxt;
                        if (count == '0) begin
                            state <= FIX;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (sel_rem) begin
                            result <= neg_r ? (~rem + 1'b1) : rem;
                        end else begin
                            result <= neg_q ? (~quo + 1'b1) : quo;
                        end
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == RUN) || (state == FIX);
    assign done     = (state == DONE);
    assign stall_EX = ((state == IDLE) && accept) || busy;

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// ============================================================================
// tb_div_sequencer : vector table, corner sequences and random ops vs a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        stall_EX;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int passed = 0;

    div_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .stall_EX (stall_EX),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // RISC-V semantics from plain arithmetic; returns fast-path flag too
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b, output bit fast);
        int sa, sb;
        fast = 1'b1;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        fast = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Present a start for one cycle; returns stall_EX seen in that cycle
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int s0);
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        s0 = stall_EX ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle; k=0 on timeout
    task automatic wait_done(output int k, output logic [31:0] res, output int st);
        k = 0; st = 0; res = 32'hDEAD_BEEF;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                k = i; res = result;
                break;
            end
            if (stall_EX) st++;
            @(posedge clk); #1;
        end
        if (k == 0) $display("FAIL timeout: no done within 100 cycles (got 0 expected 1)");
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls);
        int s0, st;
        launch(o, a, b, s0);
        wait_done(lat, res, st);
        stalls = s0 + st;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] res, exp;
        int lat, stalls, k, st, s0, dones;
        bit fast;

        vt[0] = '{2'b00, 32'd100,        32'd7,          32'd14,         34};
        vt[1] = '{2'b10, 32'd100,        32'd7,          32'd2,          34};
        vt[2] = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        vt[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        vt[4] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
        vt[5] = '{2'b11, 32'hFFFF_FFFF,  32'd16,         32'd15,         34};
        vt[6] = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vt[7] = '{2'b10, 32'd5,          32'd0,          32'd5,          1};
        vt[8] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vt[9] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
        @(negedge clk);
        check("reset_stall", {31'd0, stall_EX}, 32'd0);
        check("reset_busy",  {31'd0, busy},     32'd0);
        check("reset_done",  {31'd0, done},     32'd0);
        check("reset_result", result,           32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, res, lat, stalls);
            check($sformatf("vec%0d_result", i), res, vt[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            // stall spans the start cycle through the cycle before done
            check($sformatf("vec%0d_stalls", i), stalls, vt[i].lat);
        end

        // flush in RUN: no done, result keeps DIVU 9/3 value
        run_op(2'b01, 32'd9, 32'd3, res, lat, stalls);
        check("pre_flush_result", res, 32'd3);
        launch(2'b00, 32'd100, 32'd7, s0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'd0, busy}, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("flush_no_done", dones, 0);
        check("flush_result_kept", result, 32'd3);

        // flush in IDLE blocks a same-edge start
        @(posedge clk); #1;
        op = 2'b00; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("idle_flush_stall", {31'd0, stall_EX}, 32'd0);
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // start during RUN cycle 5 is ignored
        launch(2'b00, 32'd100, 32'd7, s0);
        repeat (4) @(posedge clk);
        #1 op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(k, res, st);
        check("ignored_start_result", res, 32'd14);
        check("ignored_start_latency", k, 34 - 5);
        @(posedge clk); #1;
        @(negedge clk);
        check("ignored_start_not_queued", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // async reset mid-RUN
        launch(2'b00, 32'd100, 32'd7, s0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_stall", {31'd0, stall_EX}, 32'd0);
        check("async_rst_busy",  {31'd0, busy},     32'd0);
        check("async_rst_result", result,           32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b01, 32'd9, 32'd3, res, lat, stalls);
        check("post_rst_result", res, 32'd3);
        check("post_rst_latency", lat, 34);

        // back-to-back: second start in the DONE cycle
        launch(2'b00, 32'd100, 32'd7, s0);
        wait_done(k, res, st);
        check("b2b_first_result", res, 32'd14);
        op = 2'b10; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("b2b_accepted_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        wait_done(k, res, st);
        check("b2b_second_result", res, 32'd2);
        check("b2b_second_latency", k + 1, 34);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        @(posedge clk); #1;

        // random ops vs reference model
        for (int n = 0; n < 30; n++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            exp = ref_div(o, a, b, fast);
            run_op(o, a, b, res, lat, stalls);
            check($sformatf("rand%0d_op%0d_%h_%h", n, o, a, b), res, exp);
            check($sformatf("rand%0d_latency", n), lat, fast ? 1 : 34);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
